// File: rtl/bcd_counter_n.sv
// bcd_counter_n: parametrised N-digit BCD up/down counter with parallel load,
// synchronous clear to RESET_VAL, wrap or saturate at the range ends,
// carry/borrow pulses and sticky over/underflow flags.
// Optional feature macro: BCD_COUNTER_DIVMOD_EN -- when defined, an
// incremental mod-3 residue drives div3 and digit 0 drives div5; when
// undefined, div3 and div5 are tied low.
module bcd_counter_n #(
  parameter int DIGITS    = 3,
  parameter int RESET_VAL = 1,
  parameter int WRAP      = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                inc,
  input  logic                dec,
  output logic [4*DIGITS-1:0] count,
  output logic                carry_out,
  output logic                borrow_out,
  output logic                overflow,
  output logic                underflow,
  output logic                at_max,
  output logic                at_zero,
  output logic                div3,
  output logic                div5
);

  localparam int W = 4 * DIGITS;

  // Integer to packed BCD, digit 0 in the low nibble.
  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] res;
    int           t;
    res = '0;
    t   = v;
    for (int k = 0; k < DIGITS; k++) begin
      res[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return res;
  endfunction

  // Any nibble above 9 becomes 9; legal digits pass through.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] res;
    res = v;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) res[4*k +: 4] = 4'd9;
    end
    return res;
  endfunction

  localparam logic [W-1:0] RESET_BCD = to_bcd(RESET_VAL);
  localparam logic [W-1:0] ALL9      = {DIGITS{4'h9}};
  localparam logic         RST_MAX   = (RESET_BCD == ALL9);
  localparam logic         RST_ZERO  = (RESET_VAL == 0);

  logic [W-1:0] r_count;
  logic         r_carry;
  logic         r_borrow;
  logic         r_ovf;
  logic         r_unf;
  logic         r_at_max;
  logic         r_at_zero;

  logic [W-1:0] w_cnt_inc;
  logic [W-1:0] w_cnt_dec;
  logic [W-1:0] w_load_bcd;
  logic         w_inc_only;
  logic         w_dec_only;
  logic [W-1:0] w_nxt_count;
  logic         w_nxt_carry;
  logic         w_nxt_borrow;
  logic         w_nxt_ovf;
  logic         w_nxt_unf;

  assign w_inc_only = inc & ~dec;
  assign w_dec_only = dec & ~inc;
  assign w_load_bcd = clamp_bcd(load_val);

  // Ripple +1 and -1 across the digits; a digit moves only when every lower
  // digit is at its roll-over value (9 going up, 0 going down).
  always_comb begin
    logic up_chain;
    logic dn_chain;
    w_cnt_inc = r_count;
    w_cnt_dec = r_count;
    up_chain  = 1'b1;
    dn_chain  = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (up_chain) begin
        w_cnt_inc[4*k +: 4] = (r_count[4*k +: 4] == 4'd9) ? 4'd0
                                                           : r_count[4*k +: 4] + 4'd1;
      end
      if (dn_chain) begin
        w_cnt_dec[4*k +: 4] = (r_count[4*k +: 4] == 4'd0) ? 4'd9
                                                           : r_count[4*k +: 4] - 4'd1;
      end
      up_chain = up_chain & (r_count[4*k +: 4] == 4'd9);
      dn_chain = dn_chain & (r_count[4*k +: 4] == 4'd0);
    end
  end

  // Command priority: clear, then load, then a lone inc or dec. At a range
  // end the registered at_max/at_zero decide between wrap and saturate.
  always_comb begin
    w_nxt_count  = r_count;
    w_nxt_carry  = 1'b0;
    w_nxt_borrow = 1'b0;
    w_nxt_ovf    = r_ovf;
    w_nxt_unf    = r_unf;
    if (clear) begin
      w_nxt_count = RESET_BCD;
      w_nxt_ovf   = 1'b0;
      w_nxt_unf   = 1'b0;
    end else if (load) begin
      w_nxt_count = w_load_bcd;
      w_nxt_ovf   = 1'b0;
      w_nxt_unf   = 1'b0;
    end else if (w_inc_only) begin
      if (r_at_max) begin
        if (WRAP != 0) begin
          w_nxt_count = w_cnt_inc;
          w_nxt_carry = 1'b1;
        end else begin
          w_nxt_ovf = 1'b1;
        end
      end else begin
        w_nxt_count = w_cnt_inc;
      end
    end else if (w_dec_only) begin
      if (r_at_zero) begin
        if (WRAP != 0) begin
          w_nxt_count  = w_cnt_dec;
          w_nxt_borrow = 1'b1;
        end else begin
          w_nxt_unf = 1'b1;
        end
      end else begin
        w_nxt_count = w_cnt_dec;
      end
    end
  end

  // Count, pulses, sticky flags and end-of-range flags all update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= RESET_BCD;
      r_carry   <= 1'b0;
      r_borrow  <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_at_max  <= RST_MAX;
      r_at_zero <= RST_ZERO;
    end else begin
      r_count   <= w_nxt_count;
      r_carry   <= w_nxt_carry;
      r_borrow  <= w_nxt_borrow;
      r_ovf     <= w_nxt_ovf;
      r_unf     <= w_nxt_unf;
      r_at_max  <= (w_nxt_count == ALL9);
      r_at_zero <= (w_nxt_count == '0);
    end
  end

  assign count      = r_count;
  assign carry_out  = r_carry;
  assign borrow_out = r_borrow;
  assign overflow   = r_ovf;
  assign underflow  = r_unf;
  assign at_max     = r_at_max;
  assign at_zero    = r_at_zero;

`ifdef BCD_COUNTER_DIVMOD_EN
  // 10 = 1 (mod 3), so the digit sum has the same residue as the value.
  function automatic logic [1:0] mod3_bcd(input logic [W-1:0] v);
    int s;
    s = 0;
    for (int k = 0; k < DIGITS; k++) s = s + int'(v[4*k +: 4]);
    return 2'(s % 3);
  endfunction

  localparam logic [1:0] RST_RES = 2'(RESET_VAL % 3);
  localparam logic       RST_D5  = ((RESET_VAL % 5) == 0);

  logic [1:0] r_res;
  logic       r_div3;
  logic       r_div5;
  logic [1:0] w_nxt_res;

  // Residue follows the count by +/-1; both wraps land on a multiple of 3
  // (0 or all-9s) so the residue is forced to 0 there.
  always_comb begin
    w_nxt_res = r_res;
    if (clear) begin
      w_nxt_res = RST_RES;
    end else if (load) begin
      w_nxt_res = mod3_bcd(w_load_bcd);
    end else if (w_inc_only) begin
      if (r_at_max) begin
        if (WRAP != 0) w_nxt_res = 2'd0;
      end else begin
        w_nxt_res = (r_res == 2'd2) ? 2'd0 : r_res + 2'd1;
      end
    end else if (w_dec_only) begin
      if (r_at_zero) begin
        if (WRAP != 0) w_nxt_res = 2'd0;
      end else begin
        w_nxt_res = (r_res == 2'd0) ? 2'd2 : r_res - 2'd1;
      end
    end
  end

  // Divisibility flags registered in step with the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res  <= RST_RES;
      r_div3 <= (RST_RES == 2'd0);
      r_div5 <= RST_D5;
    end else begin
      r_res  <= w_nxt_res;
      r_div3 <= (w_nxt_res == 2'd0);
      r_div5 <= (w_nxt_count[3:0] == 4'd0) || (w_nxt_count[3:0] == 4'd5);
    end
  end

  assign div3 = r_div3;
  assign div5 = r_div5;
`else
  assign div3 = 1'b0;
  assign div5 = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_counter_n.sv
// Testbench for bcd_counter_n (DIGITS=3, RESET_VAL=1): one wrapping and one
// saturating instance share the same stimulus.
module tb_bcd_counter_n;

`ifdef BCD_COUNTER_DIVMOD_EN
  localparam bit DM = 1'b1;
`else
  localparam bit DM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [11:0] load_val = '0;
  logic        inc = 1'b0;
  logic        dec = 1'b0;

  logic [11:0] w_count, s_count;
  logic w_cy, w_bw, w_ovf, w_unf, w_max, w_zero, w_d3, w_d5;
  logic s_cy, s_bw, s_ovf, s_unf, s_max, s_zero, s_d3, s_d5;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(3), .RESET_VAL(1), .WRAP(1)) u_w (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
    .inc(inc), .dec(dec), .count(w_count), .carry_out(w_cy), .borrow_out(w_bw),
    .overflow(w_ovf), .underflow(w_unf), .at_max(w_max), .at_zero(w_zero),
    .div3(w_d3), .div5(w_d5));

  bcd_counter_n #(.DIGITS(3), .RESET_VAL(1), .WRAP(0)) u_s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
    .inc(inc), .dec(dec), .count(s_count), .carry_out(s_cy), .borrow_out(s_bw),
    .overflow(s_ovf), .underflow(s_unf), .at_max(s_max), .at_zero(s_zero),
    .div3(s_d3), .div5(s_d5));

  typedef struct {
    logic        clr;
    logic        ld;
    logic [11:0] lv;
    logic        inc;
    logic        dec;
    logic [11:0] exp;
    logic        cy;
    logic        bw;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic c, logic l, logic [11:0] v, logic i, logic d,
                              logic [11:0] e, logic cy, logic bw);
    vec_t r;
    r.clr = c; r.ld = l; r.lv = v; r.inc = i; r.dec = d;
    r.exp = e; r.cy = cy; r.bw = bw;
    return r;
  endfunction

  function automatic int bcd2int(logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [11:0] int2bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Count plus the derived flags, with flags computed from the decimal value.
  task automatic chk_w(string tag, logic [11:0] e, logic cy, logic bw);
    int v;
    v = bcd2int(e);
    chk({tag, " count"}, 32'(w_count), 32'(e));
    chk({tag, " carry"}, 32'(w_cy), 32'(cy));
    chk({tag, " borrow"}, 32'(w_bw), 32'(bw));
    chk({tag, " at_max"}, 32'(w_max), 32'(v == 999));
    chk({tag, " at_zero"}, 32'(w_zero), 32'(v == 0));
    chk({tag, " div3"}, 32'(w_d3), 32'(DM && (v % 3 == 0)));
    chk({tag, " div5"}, 32'(w_d5), 32'(DM && (v % 5 == 0)));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic c, logic l, logic [11:0] v, logic i, logic d);
    clear = c; load = l; load_val = v; inc = i; dec = d;
  endtask

  initial begin
    // Table: 15 increments from 001, then wrap, priority and clamp cases.
    for (int i = 2; i <= 16; i++) tbl.push_back(mk(0, 0, 12'h000, 1, 0, int2bcd(i), 0, 0));
    tbl.push_back(mk(0, 1, 12'h999, 0, 0, 12'h999, 0, 0));
    tbl.push_back(mk(0, 0, 12'h000, 1, 0, 12'h000, 1, 0));
    tbl.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 0, 0));
    tbl.push_back(mk(0, 0, 12'h000, 0, 1, 12'h999, 0, 1));
    tbl.push_back(mk(0, 0, 12'h000, 0, 0, 12'h999, 0, 0));
    tbl.push_back(mk(0, 1, 12'h042, 0, 0, 12'h042, 0, 0));
    tbl.push_back(mk(1, 1, 12'h100, 1, 0, 12'h001, 0, 0));
    tbl.push_back(mk(0, 1, 12'h100, 0, 0, 12'h100, 0, 0));
    tbl.push_back(mk(0, 0, 12'h000, 1, 1, 12'h100, 0, 0));
    tbl.push_back(mk(0, 0, 12'h000, 0, 1, 12'h099, 0, 0));
    tbl.push_back(mk(0, 0, 12'h000, 1, 0, 12'h100, 0, 0));
    tbl.push_back(mk(0, 1, 12'hFAB, 0, 0, 12'h999, 0, 0));
    tbl.push_back(mk(0, 0, 12'h000, 1, 0, 12'h000, 1, 0));

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    chk_w("reset", 12'h001, 1'b0, 1'b0);
    chk("reset ovf", 32'(w_ovf), 32'd0);
    chk("reset unf", 32'(w_unf), 32'd0);
    chk("reset sat count", 32'(s_count), 32'h001);
    rst_n = 1'b1;

    for (int n = 0; n < tbl.size(); n++) begin
      drive(tbl[n].clr, tbl[n].ld, tbl[n].lv, tbl[n].inc, tbl[n].dec);
      step();
      chk_w($sformatf("vec%0d", n), tbl[n].exp, tbl[n].cy, tbl[n].bw);
    end

    // Saturating instance: overflow at 999, then clamped load clears it.
    drive(0, 1, 12'h999, 0, 0); step();
    drive(0, 0, 12'h000, 1, 0); step();
    chk("sat inc1 count", 32'(s_count), 32'h999);
    chk("sat inc1 ovf", 32'(s_ovf), 32'd1);
    chk("sat inc1 carry", 32'(s_cy), 32'd0);
    step();
    chk("sat inc2 count", 32'(s_count), 32'h999);
    chk("sat inc2 ovf", 32'(s_ovf), 32'd1);
    chk("sat inc2 carry", 32'(s_cy), 32'd0);
    chk("sat at_max", 32'(s_max), 32'd1);
    drive(0, 1, 12'h09F, 0, 0); step();
    chk("sat load count", 32'(s_count), 32'h099);
    chk("sat load ovf", 32'(s_ovf), 32'd0);
    chk("sat load div3", 32'(s_d3), 32'(DM));
    // Underflow at 000, then clear.
    drive(0, 1, 12'h000, 0, 0); step();
    drive(0, 0, 12'h000, 0, 1); step();
    chk("sat dec count", 32'(s_count), 32'h000);
    chk("sat dec unf", 32'(s_unf), 32'd1);
    chk("sat dec borrow", 32'(s_bw), 32'd0);
    drive(1, 0, 12'h000, 0, 0); step();
    chk("sat clear count", 32'(s_count), 32'h001);
    chk("sat clear unf", 32'(s_unf), 32'd0);

    // Asynchronous reset while streaming increments from 057.
    drive(0, 1, 12'h057, 0, 0); step();
    drive(0, 0, 12'h000, 1, 0); step();
    chk("stream count", 32'(w_count), 32'h058);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst count", 32'(w_count), 32'h001);
    chk("async rst sat count", 32'(s_count), 32'h001);
    chk("async rst at_zero", 32'(w_zero), 32'd0);
    #1 rst_n = 1'b1;
    step();
    chk_w("post rst inc", 12'h002, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
# bcd_counter_n

Parametrised N-digit BCD up/down counter for the FizzBuzz datapath and display path. It supersedes the fixed 3-digit increment-only counter. Adds decrement, parallel load, synchronous clear to a configurable start value, wrap/saturate mode, carry/borrow pulses and sticky over/underflow flags. Optionally tracks divisibility by 3 and 5 incrementally, so the FizzBuzz decision logic needs no divider.

## Interface
- `DIGITS`, 3: number of BCD digits; legal range 1–8.
- `RESET_VAL`, 1: start value as an integer, 0 ≤ RESET_VAL ≤ 10^DIGITS−1. It is loaded on reset and on `clear`.
- `WRAP`, 1: 1 = wrap at the ends of the range; 0 = saturate at the ends.

- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous return to RESET_VAL.
- `load`  in  1: synchronous parallel load of `load_val`.
- `load_val`  in  4*DIGITS: BCD load value; digit 0 is in [3:0].
- `inc`  in  1: count up by 1 this cycle.
- `dec`  in  1: count down by 1 this cycle.
- `count`  out  4*DIGITS: registered BCD value; digit 0 is in [3:0].
- `carry_out`  out  1: one-cycle pulse when the counter wraps from all-9s to 0.
- `borrow_out`  out  1: one-cycle pulse when the counter wraps from 0 to all-9s.
- `overflow`  out  1: sticky; set when `inc` is applied at max with WRAP=0.
- `underflow`  out  1: sticky; set when `dec` is applied at 0 with WRAP=0.
- `at_max`  out  1: registered; high when `count` is all 9s.
- `at_zero`  out  1: registered; high when `count` is 0.
- `div3`  out  1: registered; high when `count` mod 3 = 0.
- `div5`  out  1: registered; high when `count` mod 5 = 0.

## Operation
Command priority, evaluated per cycle:
- `clear` overrides `load`, which overrides `inc`/`dec`.
- `inc` and `dec` both high: no change, no pulse.

Increment:
- Digit k increments when all lower digits are 9.
- Each digit that is 9 with all lower digits 9 goes to 0.
- At all-9s with WRAP=1: `count` becomes 0 and `carry_out` pulses.
- At all-9s with WRAP=0: `count` holds, `overflow` sets, no pulse.

Decrement (mirror of increment):
- Digit k decrements when all lower digits are 0.
- Each digit that is 0 with all lower digits 0 goes to 9.
- At 0 with WRAP=1: `count` becomes all-9s and `borrow_out` pulses.
- At 0 with WRAP=0: `count` holds and `underflow` sets.

Load:
- Any `load_val` digit greater than 9 is clamped to 9; other digits load unchanged.
- `load` clears `overflow` and `underflow`.

Clear:
- `count` becomes RESET_VAL; `overflow` and `underflow` clear.

Output flags:
- `at_max`, `at_zero`, `div3` and `div5` always describe the current `count`.
- They are registered alongside `count`, never derived combinationally from it.

## Timing
- Command-to-output latency: a command sampled at edge n is visible on `count` and all flags after edge n.
- `carry_out` and `borrow_out` are high for exactly the cycle after the wrapping edge.
- Back-to-back `inc` every cycle is legal; counting runs at the full clock rate.
- Reset values (`rst_n` low, asynchronous):
  - `count` = RESET_VAL in BCD.
  - `carry_out`, `borrow_out`, `overflow`, `underflow` = 0.
  - `at_max`, `at_zero`, `div3`, `div5` = values consistent with RESET_VAL.
- Reset asserted mid-sequence: all state is abandoned immediately; the first command is accepted on the first edge after `rst_n` rises.

## Configuration
`BCD_COUNTER_DIVMOD_EN`:
- Defined:
  - A 2-bit mod-3 residue register tracks `count`: +1 mod 3 on `inc`, −1 mod 3 on `dec`.
  - The residue is 0 on either wrap, since all-9s is divisible by 3.
  - On load or clear, the residue is recomputed as (sum of digits) mod 3.
  - `div3` = (residue == 0).
  - `div5` = (digit 0 == 0 or digit 0 == 5).
  - Both are registered with `count`.
- Undefined: the residue logic is absent and `div3`/`div5` are tied to 0.

## Test plan
- Reset with DIGITS=3, RESET_VAL=1:
  - Expect `count`=001, `at_zero`=0.
  - With the macro, expect `div3`=0 and `div5`=0.
- 15 consecutive `inc` from 001:
  - Expect `count`=016.
  - Expect `div3` high at 003, 006, 009, 012, 015.
  - Expect `div5` high at 005, 010, 015.
- WRAP=1: load 999, then `inc`:
  - Expect `count`=000, a one-cycle `carry_out`, and `at_zero`=1.
  - Then `dec`: expect 999 and a one-cycle `borrow_out`.
- WRAP=0: load 999, then `inc` ×2:
  - Expect `count` to hold at 999 with `overflow`=1 and no `carry_out`.
  - Then `load` 0x09F: expect `count`=099 (clamped) and `overflow`=0.
- Assert `clear`, `load`, `inc` together from 042: expect `count`=001 on the next cycle.
- Assert `inc`+`dec` together at 100: expect 100, no pulse.
- Drive `rst_n` low while streaming `inc` from 057: expect an immediate `count`=001 before the next edge.
